// File: rtl/if_id_stage_reg_pkg.sv
// Shared definitions for the IF/ID pipeline register: default widths,
// the bubble instruction word and the stage-register control encoding.
package if_id_stage_reg_pkg;

    localparam int          DATA_W_DEF    = 32;
    localparam int          CNT_W_DEF     = 16;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    // Prioritised action the stage register takes at the next edge.
    typedef enum logic [1:0] {
        CTL_LOAD   = 2'd0,
        CTL_HOLD   = 2'd1,
        CTL_BUBBLE = 2'd2
    } stage_ctl_t;

    // Flush beats freeze: a held wrong-path instruction must still die.
    function automatic stage_ctl_t decode_ctl(input logic flush, input logic freeze);
        if (flush) begin
            return CTL_BUBBLE;
        end else if (freeze) begin
            return CTL_HOLD;
        end
        return CTL_LOAD;
    endfunction

endpackage

// File: rtl/if_id_stage_reg_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Increment on request unless already at the maximum value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with freeze (hold), flush (bubble) and
// saturating hazard-activity counters. All outputs are registered.
module if_id_stage_reg
    import if_id_stage_reg_pkg::*;
#(
    parameter int          DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] NOP_INSTR = NOP_INSTR_DEF[DATA_W-1:0],
    parameter int          CNT_W     = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] instruction_in,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] instruction_out,
    output logic              valid_out,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    stage_ctl_t ctl;
    logic       stall_inc;
    logic       flush_inc;

    // Resolve the control inputs into one action; counters only see
    // activity that affects a real (valid) entry.
    always_comb begin
        ctl       = decode_ctl(flush, freeze);
        stall_inc = (ctl == CTL_HOLD)   && valid_out;
        flush_inc = (ctl == CTL_BUBBLE) && valid_out;
    end

    // Stage register: load, hold, or replace with a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out          <= '0;
            instruction_out <= NOP_INSTR;
            valid_out       <= 1'b0;
        end else begin
            case (ctl)
                CTL_BUBBLE: begin
                    pc_out          <= '0;
                    instruction_out <= NOP_INSTR;
                    valid_out       <= 1'b0;
                end
                CTL_HOLD: begin
                    pc_out          <= pc_out;
                    instruction_out <= instruction_out;
                    valid_out       <= valid_out;
                end
                default: begin
                    pc_out          <= pc_in;
                    instruction_out <= valid_in ? instruction_in : NOP_INSTR;
                    valid_out       <= valid_in;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Bench for if_id_stage_reg: directed scenarios then randomized traffic,
// compared against a cycle-level reference model of the stage behaviour.
module tb_if_id_stage_reg;

    localparam int          DATA_W = 32;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam int          CMAX   = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              freeze;
    logic              flush;
    logic              valid_in;
    logic [DATA_W-1:0] pc_in;
    logic [DATA_W-1:0] instruction_in;
    logic [DATA_W-1:0] pc_out;
    logic [DATA_W-1:0] instruction_out;
    logic              valid_out;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;

    int passed = 0;
    int total  = 0;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    int          m_stall;
    int          m_flush;

    if_id_stage_reg #(
        .DATA_W    (DATA_W),
        .NOP_INSTR (NOP),
        .CNT_W     (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .flush           (flush),
        .valid_in        (valid_in),
        .pc_in           (pc_in),
        .instruction_in  (instruction_in),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    pc_out,             m_pc);
        check({tag, ".instr"}, instruction_out,    m_instr);
        check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, m_valid});
        check({tag, ".stall"}, {28'd0, stall_count}, m_stall[31:0]);
        check({tag, ".flush"}, {28'd0, flush_count}, m_flush[31:0]);
    endtask

    task automatic model_reset();
        m_pc = 0; m_instr = NOP; m_valid = 0; m_stall = 0; m_flush = 0;
    endtask

    // One clock of traffic: drive at negedge, let the edge happen, update
    // the model by the stage rules, compare at the following negedge.
    task automatic step(input string tag, input logic fr, input logic fl,
                        input logic vi, input logic [31:0] pc, input logic [31:0] ins);
        freeze = fr; flush = fl; valid_in = vi; pc_in = pc; instruction_in = ins;
        @(posedge clk);
        @(negedge clk);
        if (fl) begin
            if (m_valid && m_flush < CMAX) m_flush++;
            m_pc = 0; m_instr = NOP; m_valid = 0;
        end else if (fr) begin
            if (m_valid && m_stall < CMAX) m_stall++;
        end else begin
            m_pc = pc; m_instr = vi ? ins : NOP; m_valid = vi;
        end
        check_all(tag);
    endtask

    // Assert reset between edges and confirm it acts without a clock.
    task automatic mid_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; freeze = 0; flush = 0; valid_in = 1;
        pc_in = 32'h40; instruction_in = 32'h1234_5678;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("por");
        rst = 1'b0;

        // normal flow
        step("load0", 0, 0, 1, 32'h0, 32'h0022_0000);
        step("load4", 0, 0, 1, 32'h4, 32'h0062_0000);
        step("load8", 0, 0, 1, 32'h8, 32'h00A2_0000);

        // freeze three cycles with changing input
        step("frz1", 1, 0, 1, 32'hC,  32'h1111_1111);
        step("frz2", 1, 0, 1, 32'h10, 32'h2222_2222);
        step("frz3", 1, 0, 1, 32'h14, 32'h3333_3333);

        // flush wins over freeze, then flush a bubble
        step("flfrz", 1, 1, 1, 32'h18, 32'h4444_4444);
        step("flbub", 0, 1, 1, 32'h1C, 32'h5555_5555);

        // saturation of stall counter
        step("reload", 0, 0, 1, 32'h100, 32'hDEAD_BEEF);
        for (int i = 0; i < 20; i++) step("sat", 1, 0, 1, 32'h200 + i, 32'hCAFE_0000 + i);

        // reset in the middle of a freeze, then normal load
        freeze = 1'b1;
        mid_reset("rst_frz");
        step("post_rst", 0, 0, 1, 32'h40, 32'h0011_0000);

        // bubble load, then freeze on the bubble must not count
        step("bubble", 0, 0, 0, 32'h44, 32'hFFFF_FFFF);
        step("bub_frz", 1, 0, 1, 32'h48, 32'h0033_0000);

        // reset during a flush
        flush = 1'b1;
        mid_reset("rst_fl");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic fr, fl, vi;
            fr = ($urandom_range(0, 99) < 35);
            fl = ($urandom_range(0, 99) < 15);
            vi = ($urandom_range(0, 99) < 80);
            step("rand", fr, fl, vi, $urandom, $urandom);
            if (i == 200) mid_reset("rst_rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
